row_deserializer: RTL and testbench
===================================

# row_deserializer

Receive-side counterpart of the pixel output buffer. It collects a row burst of `OUTPUT_BUS_WIDTH`-pixel beats from the readout bus and reassembles the full `PIXEL_ARRAY_WIDTH`-pixel row. It hands each completed row downstream over a valid/ready handshake through a one-row holding register, so the next burst can be received while the previous row waits. It sits between the sensor readout bus and the frame-capture/processing logic, and detects truncated bursts and row overruns.

## Interface
Parameters:
- `PIXEL_ARRAY_WIDTH`, default 8: pixels per row; must be a multiple of `OUTPUT_BUS_WIDTH`.
- `OUTPUT_BUS_WIDTH`, default 2: pixels per bus beat.
- `PIXEL_BITS`, default 8: bits per pixel.
- Derived: `BEATS = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH`; beat counter width `max(1, $clog2(BEATS))`.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `bus_en`, input, 1: beat strobe; high for exactly `BEATS` consecutive cycles per row.
- `bus_data`, input, `[OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]`: beat payload.
- `row_valid`, output, 1: holding register contains a row.
- `row_ready`, input, 1: downstream accepts the row.
- `row_data`, output, `[PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]`: assembled row.
- `row_count`, output, 16: number of rows loaded into the holding register; wraps at 65535 to 0.
- `overrun`, output, 1: sticky flag; a completed row was dropped.
- `frame_error`, output, 1: one-cycle pulse; a burst was truncated.
- `clear_flags`, input, 1: synchronously clears `overrun`.

## Operation
- States:
  - IDLE: no burst in progress.
  - RECEIVE: burst in progress; `beat_cnt` holds the next slice index.
- Beat mapping: beat i writes pixels `[i*OUTPUT_BUS_WIDTH +: OUTPUT_BUS_WIDTH]` of the assembly buffer. `bus_data[0]` is the lowest pixel index, so beat 0 carries pixels 0..B-1.
- IDLE with `bus_en=1`:
  - Write slice 0.
  - If `BEATS==1`, the row completes.
  - Otherwise set `beat_cnt=1` and go to RECEIVE.
- RECEIVE with `bus_en=1`:
  - Write slice `beat_cnt`.
  - If `beat_cnt==BEATS-1`, the row completes, `beat_cnt` becomes 0 and the state goes to IDLE.
  - Otherwise increment `beat_cnt`.
- RECEIVE with `bus_en=0`:
  - Truncated burst: the partial row is discarded and never reaches `row_data`.
  - Pulse `frame_error` for one cycle.
  - `beat_cnt` becomes 0; state goes to IDLE.
- Row completion on a given edge:
  - If the holding register is empty, or `row_valid && row_ready` in that cycle, load the holding register with the full row (including the final beat's slice), set `row_valid=1` and increment `row_count`.
  - Otherwise drop the row, set `overrun=1`, and leave `row_count` and `row_data` unchanged.
- Back-to-back bursts: `bus_en` held high past `BEATS` beats starts the next row with no gap cycle.
- Handshake:
  - `row_valid` drops after an accept edge (`row_valid && row_ready`) unless a new row loads on the same edge.
  - `row_data` stays stable while `row_valid && !row_ready`.
- `clear_flags` clears `overrun`. If it coincides with a new overrun event, set wins (`overrun=1`).

## Timing
- Reset values: `row_valid=0`, `row_data=0`, `row_count=0`, `overrun=0`, `frame_error=0`; state IDLE, `beat_cnt=0`, assembly buffer 0.
- Reset asserted mid-burst discards the partial row. After release, the first `bus_en` cycle is treated as beat 0.
- Latency:
  - Final beat sampled at edge k → `row_valid=1` and `row_data` valid after edge k.
  - `row_count` updates on the same edge k.
- `frame_error` is asserted after the first edge that samples `bus_en=0` in RECEIVE, and deasserted after the next edge.
- Holding register full, `row_ready` held low: the assembly buffer keeps accepting beats. Only at completion is the row dropped.
- Accept and completion on the same edge: the new row loads, `row_valid` stays 1 and there is no overrun.
- Throughput: one beat per cycle sustained; one row per `BEATS` cycles with `row_ready=1`.

## Test plan
- Defaults; after reset, 4 beats `{0x01,0x00}`, `{0x03,0x02}`, `{0x05,0x04}`, `{0x07,0x06}` with `row_ready=1` → `row_data` pixels 0..7 = 0x00..0x07, `row_valid` high the cycle after beat 4 for 1 cycle, `row_count=1`.
- Two back-to-back bursts (8 cycles of `bus_en`), `row_ready=1` → two rows delivered 4 cycles apart, `row_count=2`, `overrun=0`, no `frame_error`.
- `row_ready=0`, three full bursts → first row held unchanged, second row loads into nothing, `overrun=1` after the second completion, `row_count=1`. `clear_flags` pulse → `overrun=0`.
- Burst of 2 beats then `bus_en=0`, then a full burst → `frame_error` pulses once, delivered row holds only the second burst's data, `row_count=1`.
- Assert `reset` after beat 2 of a burst, release, send a full burst → no row from the first burst, correct second row, all outputs 0 during reset.
- `row_ready` rises on the same edge as a completion while `row_valid=1` → old row accepted, new row loaded, `row_valid` stays 1, `overrun=0`.

Source files
------------

// File: rtl/row_deserializer_if.sv
// rtl/row_deserializer_if.sv - readout-bus beats in, assembled rows out
interface row_deserializer_if #(
    parameter int PIXEL_ARRAY_WIDTH = 8,
    parameter int OUTPUT_BUS_WIDTH  = 2,
    parameter int PIXEL_BITS        = 8
);
    logic                                              bus_en;
    logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]       bus_data;
    logic                                              row_valid;
    logic                                              row_ready;
    logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]      row_data;

    // master is the environment (bus source plus row consumer), slave is the deserializer
    modport master (
        output bus_en, bus_data, row_ready,
        input  row_valid, row_data
    );

    modport slave (
        input  bus_en, bus_data, row_ready,
        output row_valid, row_data
    );
endinterface

// File: rtl/row_deserializer.sv
// rtl/row_deserializer.sv - reassembles row bursts and hands rows out via a holding register
module row_deserializer #(
    parameter int PIXEL_ARRAY_WIDTH = 8,
    parameter int OUTPUT_BUS_WIDTH  = 2,
    parameter int PIXEL_BITS        = 8
) (
    input  logic                clk,
    input  logic                reset,
    row_deserializer_if.slave   bus,
    output logic [15:0]         row_count,
    output logic                overrun,
    output logic                frame_error,
    input  logic                clear_flags
);
    localparam int BEATS = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, RECEIVE} state_t;

    state_t                                         state_q, state_d;
    logic [CW-1:0]                                  beat_cnt_q, beat_cnt_d;
    logic                                           last_beat;
    logic                                           complete, truncate, accept, load, drop;
    logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]   asm_q, asm_next, hold_q;
    logic                                           row_valid_q;
    logic [15:0]                                    row_count_q;
    logic                                           overrun_q, frame_error_q;

    // beat_cnt is 0 in IDLE, so it always names the slice the current beat fills
    assign last_beat = (state_q == IDLE) ? (BEATS == 1) : (beat_cnt_q == CW'(BEATS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.bus_en && !last_beat) begin
                    beat_cnt_d = CW'(1);
                    state_d    = RECEIVE;
                end
            end
            RECEIVE: begin
                if (!bus.bus_en || last_beat) begin
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            default: begin
                beat_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_comb begin
        complete = bus.bus_en && last_beat;
        truncate = (state_q == RECEIVE) && !bus.bus_en;
        accept   = row_valid_q && bus.row_ready;
        load     = complete && (!row_valid_q || accept);
        drop     = complete && !load;
    end

    // the completing beat is merged combinationally so the row loads on that same edge
    for (genvar s = 0; s < BEATS; s++) begin : g_slice
        for (genvar p = 0; p < OUTPUT_BUS_WIDTH; p++) begin : g_pix
            assign asm_next[s*OUTPUT_BUS_WIDTH+p] =
                (bus.bus_en && beat_cnt_q == CW'(s)) ? bus.bus_data[p]
                                                     : asm_q[s*OUTPUT_BUS_WIDTH+p];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q         <= '0;
            hold_q        <= '0;
            row_valid_q   <= 1'b0;
            row_count_q   <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            asm_q         <= asm_next;
            frame_error_q <= truncate;
            if (load) begin
                hold_q      <= asm_next;
                row_count_q <= row_count_q + 16'd1;
                row_valid_q <= 1'b1;
            end else if (accept) begin
                row_valid_q <= 1'b0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clear_flags) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.row_valid = row_valid_q;
    assign bus.row_data  = hold_q;
    assign row_count     = row_count_q;
    assign overrun       = overrun_q;
    assign frame_error   = frame_error_q;
endmodule

// File: tb/tb_row_deserializer.sv
// tb/tb_row_deserializer.sv - randomized self-checking bench for row_deserializer
module tb_row_deserializer;
    localparam int PAW   = 8;
    localparam int OBW   = 2;
    localparam int PB    = 8;
    localparam int BEATS = PAW / OBW;
    localparam int RW    = PAW * PB;
    localparam int SW    = OBW * PB;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_flags;
    logic [15:0] row_count;
    logic        overrun;
    logic        frame_error;

    always #5 clk = ~clk;

    row_deserializer_if #(.PIXEL_ARRAY_WIDTH(PAW), .OUTPUT_BUS_WIDTH(OBW), .PIXEL_BITS(PB)) rd ();

    row_deserializer #(.PIXEL_ARRAY_WIDTH(PAW), .OUTPUT_BUS_WIDTH(OBW), .PIXEL_BITS(PB)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (rd.slave),
        .row_count   (row_count),
        .overrun     (overrun),
        .frame_error (frame_error),
        .clear_flags (clear_flags)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pixels pile up in a queue; a full queue is a finished row,
    // a gap with a non-empty queue is a truncated burst.
    logic [PB-1:0] pend[$];
    logic [RW-1:0] m_hold;
    logic          m_valid;
    logic [15:0]   m_cnt;
    logic          m_ovr;
    logic          m_fe;
    bit            m_acc, m_loaded, m_dropped;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            m_hold  = '0;
            m_valid = 1'b0;
            m_cnt   = '0;
            m_ovr   = 1'b0;
            m_fe    = 1'b0;
        end else begin
            m_acc     = m_valid && rd.row_ready;
            m_loaded  = 1'b0;
            m_dropped = 1'b0;
            m_fe      = 1'b0;
            if (rd.bus_en) begin
                for (int p = 0; p < OBW; p++) pend.push_back(rd.bus_data[p]);
                if (pend.size() == PAW) begin
                    if (!m_valid || m_acc) begin
                        for (int p = 0; p < PAW; p++) m_hold[p*PB +: PB] = pend[p];
                        m_cnt    = m_cnt + 16'd1;
                        m_loaded = 1'b1;
                    end else begin
                        m_dropped = 1'b1;
                    end
                    pend.delete();
                end
            end else if (pend.size() != 0) begin
                m_fe = 1'b1;
                pend.delete();
            end
            if (m_loaded) m_valid = 1'b1;
            else if (m_acc) m_valid = 1'b0;
            if (m_dropped) m_ovr = 1'b1;
            else if (clear_flags) m_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("row_valid",   rd.row_valid, m_valid);
            check("row_data",    rd.row_data,  m_hold);
            check("row_count",   row_count,    m_cnt);
            check("overrun",     overrun,      m_ovr);
            check("frame_error", frame_error,  m_fe);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_beats(input logic [RW-1:0] r, input int n);
        for (int b = 0; b < n; b++) begin
            rd.bus_en   = 1'b1;
            rd.bus_data = r[b*SW +: SW];
            tick();
        end
    endtask

    function automatic logic [RW-1:0] rand_row();
        return {$urandom, $urandom};
    endfunction

    logic [RW-1:0] r1, r2, r3;

    initial begin
        reset       = 1'b1;
        clear_flags = 1'b0;
        rd.bus_en   = 1'b0;
        rd.bus_data = '0;
        rd.row_ready = 1'b0;
        tick(); tick();
        run_cmp = 1'b1;
        tick();
        check("reset_row_valid", rd.row_valid, 0);
        check("reset_row_count", row_count, 0);
        check("reset_row_data", rd.row_data, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        tick();

        // pixel ramp 0x00..0x07
        rd.row_ready = 1'b1;
        send_beats(64'h0706050403020100, BEATS);
        check("ramp_row_data", rd.row_data, 64'h0706050403020100);
        check("ramp_row_valid", rd.row_valid, 1);
        check("ramp_row_count", row_count, 1);
        rd.bus_en = 1'b0;
        tick();
        check("ramp_accepted", rd.row_valid, 0);

        // back-to-back bursts
        r1 = rand_row(); r2 = rand_row();
        send_beats(r1, BEATS);
        check("b2b_row1", rd.row_data, r1);
        check("b2b_count1", row_count, 2);
        send_beats(r2, BEATS);
        check("b2b_row2", rd.row_data, r2);
        check("b2b_count2", row_count, 3);
        rd.bus_en = 1'b0;
        tick();
        check("b2b_overrun", overrun, 0);

        // overrun with downstream stalled
        rd.row_ready = 1'b0;
        r1 = rand_row(); r2 = rand_row(); r3 = rand_row();
        send_beats(r1, BEATS);
        check("stall_count", row_count, 4);
        send_beats(r2, BEATS);
        check("stall_overrun", overrun, 1);
        check("stall_held", rd.row_data, r1);
        send_beats(r3, BEATS);
        rd.bus_en = 1'b0;
        tick();
        check("stall_held2", rd.row_data, r1);
        check("stall_count2", row_count, 4);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("clear_overrun", overrun, 0);
        rd.row_ready = 1'b1;
        tick(); tick();

        // truncated burst then a full one
        r1 = rand_row(); r2 = rand_row();
        send_beats(r1, 2);
        rd.bus_en = 1'b0;
        @(negedge clk);
        check("trunc_fe_high", frame_error, 1);
        #1;
        @(negedge clk);
        check("trunc_fe_low", frame_error, 0);
        #1;
        send_beats(r2, BEATS);
        check("trunc_row", rd.row_data, r2);
        check("trunc_count", row_count, 5);
        rd.bus_en = 1'b0;
        tick();

        // reset mid-burst
        r1 = rand_row(); r2 = rand_row();
        send_beats(r1, 2);
        rd.bus_en = 1'b0;
        reset = 1'b1;
        tick();
        check("midrst_valid", rd.row_valid, 0);
        check("midrst_count", row_count, 0);
        check("midrst_data", rd.row_data, 0);
        check("midrst_fe", frame_error, 0);
        reset = 1'b0;
        tick();
        send_beats(r2, BEATS);
        check("midrst_row", rd.row_data, r2);
        check("midrst_count2", row_count, 1);
        rd.bus_en = 1'b0;
        tick();

        // accept and completion on the same edge
        rd.row_ready = 1'b0;
        r1 = rand_row(); r2 = rand_row();
        send_beats(r1, BEATS);
        send_beats(r2, BEATS - 1);
        rd.row_ready = 1'b1;
        send_beats(r2 >> ((BEATS - 1) * SW), 1);
        check("same_edge_valid", rd.row_valid, 1);
        check("same_edge_overrun", overrun, 0);
        check("same_edge_row", rd.row_data, r2);
        check("same_edge_count", row_count, 3);
        rd.bus_en = 1'b0;
        tick();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            rd.bus_en    = ($urandom_range(0, 99) < 85);
            rd.bus_data  = SW'($urandom);
            rd.row_ready = ($urandom_range(0, 3) != 0);
            clear_flags  = ($urandom_range(0, 15) == 0);
            tick();
        end
        rd.bus_en   = 1'b0;
        clear_flags = 1'b0;
        tick(); tick();
        run_cmp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
